// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the two-port ALU arbiter.
//   ALU_OP_W        : opcode width
//   ALU_ADD..ALU_SLTU : opcode encodings understood by alu
//   arb_state_t     : arbiter FSM states
//   arb_operand_t   : one latched request (operands, opcode, issuing port)
//   alu_op_illegal  : true for encodings outside ADD..SLTU
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0]         a;
    logic [31:0]         b;
    logic [ALU_OP_W-1:0] op;
    logic                id;
  } arb_operand_t;

  // Every encoding above SLTU is unassigned.
  function automatic logic alu_op_illegal(input logic [ALU_OP_W-1:0] op);
    return (op > ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU.
//   a, b        : operands (b[4:0] is the shift amount for shifts)
//   alu_control : opcode, encodings from alu_pkg
//   result      : operation result (0 for unassigned opcodes)
//   zero        : result == 0
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic [ALU_OP_W-1:0] alu_control,
  output logic [31:0]         result,
  output logic                zero
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'b0, (a < b)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational alu between two requesters. One operation is in
// flight at a time: IDLE -> (accept) -> EXEC -> DONE -> (rsp taken) -> IDLE,
// or straight back to EXEC when a new request is accepted while the response
// is being taken. Acceptance in cycle N gives rsp_valid in cycle N+2.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin between ports, 1 = port 0 always wins a tie
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    : request handshake for port N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op    : operands and opcode for port N
//   rsp_valid / rsp_ready      : response handshake
//   rsp_id                     : port that issued the response
//   rsp_result, rsp_zero       : ALU result and result == 0
//   rsp_err                    : illegal opcode flag
//
// Build option
//   ALU_ARB_OPCHECK_EN : when defined, opcodes 1010-1111 return rsp_err=1,
//                        rsp_result=0, rsp_zero=1. When undefined rsp_err is
//                        tied low and the ALU output is returned unchanged.
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [31:0]         req0_a,
  input  logic [31:0]         req0_b,
  input  logic [ALU_OP_W-1:0] req0_op,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [31:0]         req1_a,
  input  logic [31:0]         req1_b,
  input  logic [ALU_OP_W-1:0] req1_op,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [31:0]         rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err
);

  arb_state_t   state;
  arb_state_t   state_next;

  logic         last_grant;
  logic         any_valid;
  logic         grant_id;
  logic         can_accept;
  logic         accept;

  arb_operand_t opnd;

  logic [31:0]  alu_result;
  logic         alu_zero;
  logic [31:0]  result_next;
  logic         zero_next;

  // ---------------------------------------------------------------------------
  // Port selection. last_grant = 1 after reset so port 0 wins the first tie.
  // When neither port is valid grant_id is irrelevant because accept is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. DONE falls through to EXEC when the response is taken
  // and a new request is accepted in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (any_valid) begin
          state_next = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        state_next = ARB_DONE;
      end
      ARB_DONE: begin
        if (rsp_ready) begin
          state_next = any_valid ? ARB_EXEC : ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. A request can only be taken when the response register is
  // free or is being emptied this very cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    can_accept = (state == ARB_IDLE) || ((state == ARB_DONE) && rsp_ready);
    accept     = can_accept && any_valid;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    rsp_valid  = (state == ARB_DONE);
  end

  // ---------------------------------------------------------------------------
  // Round-robin history, updated only when a request is actually accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand register: captures the granted port's request on acceptance.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd <= '0;
    end else if (accept) begin
      if (grant_id) begin
        opnd.a  <= req1_a;
        opnd.b  <= req1_b;
        opnd.op <= req1_op;
        opnd.id <= 1'b1;
      end else begin
        opnd.a  <= req0_a;
        opnd.b  <= req0_b;
        opnd.op <= req0_op;
        opnd.id <= 1'b0;
      end
    end
  end

  alu u_alu (
    .a           (opnd.a),
    .b           (opnd.b),
    .alu_control (opnd.op),
    .result      (alu_result),
    .zero        (alu_zero)
  );

`ifdef ALU_ARB_OPCHECK_EN
  logic op_illegal;
  logic rsp_err_q;

  // Illegal opcodes bypass the ALU and report an error with a zero result.
  always_comb begin
    op_illegal  = alu_op_illegal(opnd.op);
    result_next = op_illegal ? 32'd0 : alu_result;
    zero_next   = op_illegal ? 1'b1 : alu_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (state == ARB_EXEC) begin
      rsp_err_q <= op_illegal;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  always_comb begin
    result_next = alu_result;
    zero_next   = alu_zero;
  end

  assign rsp_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Response register: loaded once in EXEC, then held through DONE so the
  // outputs stay stable while the consumer stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (state == ARB_EXEC) begin
      rsp_result <= result_next;
      rsp_zero   <= zero_next;
      rsp_id     <= opnd.id;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. An observer process watches request
// handshakes, checks grant decisions and response timing against a
// transaction-level model, and queues the expected response. A separate
// monitor pops the queue whenever a response is handed over.
// Honours ALU_ARB_OPCHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int FIXED_PRIO = 0;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          zero;
    bit          err;
    bit          chk;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  int   checks   = 0;
  int   failures = 0;

  exp_t exp_q[$];
  bit   grant_log[$];

  bit   inflight    = 0;
  int   age         = 0;
  bit   last_grant_m = 1;
  bit   acc0 = 0, acc1 = 0;
  bit   exp_g, got_g, obs_can;

  alu_arbiter #(.FIXED_PRIO(FIXED_PRIO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Reference model: results computed with plain integer arithmetic.
  function automatic exp_t build_exp(input bit id, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] op);
    exp_t        e;
    int          sa, sb;
    int unsigned sh;
    longint      q, d;
    e.id  = id;
    e.err = 1'b0;
    e.chk = 1'b1;
    e.res = 32'd0;
    sh    = {27'b0, b[4:0]};
    sa    = a;
    sb    = b;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a * (32'd1 << sh);
      4'd6: e.res = a / (32'd1 << sh);
      4'd7: begin
        d = longint'(1) << sh;
        q = longint'(sa) / d;
        if (sa < 0 && (longint'(sa) % d) != 0) q = q - 1;
        e.res = q[31:0];
      end
      4'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
      default: begin
`ifdef ALU_ARB_OPCHECK_EN
        e.res = 32'd0;
        e.err = 1'b1;
`else
        e.chk = 1'b0;
`endif
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Anything queued is lost when reset hits.
  always @(negedge rst_n) exp_q.delete();

  // Observer: request-side checks and scoreboard push.
  always @(negedge clk) begin
    if (!rst_n) begin
      inflight     = 0;
      age          = 0;
      last_grant_m = 1;
    end else begin
      if (inflight) begin
        age++;
        check_bit("rsp_valid_timing", rsp_valid, (age >= 2));
      end else begin
        check_bit("rsp_valid_idle", rsp_valid, 1'b0);
      end
      obs_can = !inflight || (age >= 2 && rsp_ready);
      check_bit("req_ready_any", req0_ready | req1_ready, obs_can && (req0_valid || req1_valid));
      check_bit("req_ready_onehot", req0_ready & req1_ready, 1'b0);
      if (inflight && age >= 2 && rsp_ready) inflight = 0;
      if (req0_ready || req1_ready) begin
        if (req0_valid && req1_valid) exp_g = (FIXED_PRIO != 0) ? 1'b0 : !last_grant_m;
        else                          exp_g = req1_valid;
        got_g = req1_ready;
        check_bit("grant_port", got_g, exp_g);
        grant_log.push_back(got_g);
        last_grant_m = got_g;
        if (got_g) begin
          exp_q.push_back(build_exp(1'b1, req1_a, req1_b, req1_op));
          acc1 = 1;
        end else begin
          exp_q.push_back(build_exp(1'b0, req0_a, req0_b, req0_op));
          acc0 = 1;
        end
        inflight = 1;
        age      = 0;
      end
    end
  end

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL rsp_unexpected: got response id=%0d result=0x%08h, want none", rsp_id, rsp_result);
    end else begin
      e = exp_q.pop_front();
      check_bit("rsp_id", rsp_id, e.id);
      check_bit("rsp_err", rsp_err, e.err);
      if (e.chk) begin
        check_val("rsp_result", rsp_result, e.res);
        check_bit("rsp_zero", rsp_zero, e.zero);
      end
    end
  endtask

  // Monitor: compare every response that is handed over.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) checkOutput();
  end

  task automatic applyStimulus(input int port, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] op);
    bit got;
    got = 0;
    @(posedge clk); #1;
    if (port == 1) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((port == 1) ? req1_ready : req0_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: port %0d got no ready, want ready within 50 cycles", port);
    end
    @(posedge clk); #1;
    if (port == 1) req1_valid = 0;
    else           req0_valid = 0;
  endtask

  function automatic logic [3:0] rand_op();
    if ($urandom % 8 == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  task automatic new_req(input int port);
    logic [31:0] a, b;
    a = $urandom;
    b = ($urandom % 8 == 0) ? a : $urandom;
    if (port == 1) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = rand_op();
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = rand_op();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #3;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; rsp_ready = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;

    // Reset values
    @(negedge clk);
    check_bit("reset_rsp_valid", rsp_valid, 1'b0);
    check_val("reset_rsp_result", rsp_result, 32'd0);
    check_bit("reset_rsp_zero", rsp_zero, 1'b0);
    check_bit("reset_rsp_id", rsp_id, 1'b0);
    check_bit("reset_rsp_err", rsp_err, 1'b0);
    check_bit("reset_req0_ready", req0_ready, 1'b0);
    check_bit("reset_req1_ready", req1_ready, 1'b0);

    @(posedge clk); #1 rsp_ready = 1;

    // Directed operations
    applyStimulus(0, 32'h0000_0001, 32'd4, ALU_SLL);
    applyStimulus(1, 32'h8000_0000, 32'd4, ALU_SRA);
    applyStimulus(1, 32'd5, 32'd10, ALU_SLT);
    applyStimulus(0, 32'd7, 32'd7, ALU_SUB);
    applyStimulus(0, 32'd1, 32'hFFFF_FFFF, ALU_SLTU);
    applyStimulus(1, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
    applyStimulus(0, 32'h1234_5678, 32'hFFFF_FFE3, ALU_SRL);
    applyStimulus(0, 32'd3, 32'd5, 4'hF);
    repeat (4) @(negedge clk);

    // Consumer stall in DONE with a request waiting on port 1
    @(posedge clk); #1 rsp_ready = 0;
    applyStimulus(0, 32'd3, 32'd4, ALU_ADD);
    @(posedge clk); #1;
    req1_valid = 1; req1_a = 32'd10; req1_b = 32'd3; req1_op = ALU_SUB;
    repeat (5) begin
      @(negedge clk);
      check_val("stall_result", rsp_result, 32'd7);
      check_bit("stall_rsp_valid", rsp_valid, 1'b1);
      check_bit("stall_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    check_bit("stall_release_accept", req1_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 0;
    repeat (4) @(negedge clk);

    // Reset while an operation is in EXEC
    applyStimulus(0, 32'd9, 32'd9, ALU_ADD);
    #2 rst_n = 0;
    @(posedge clk); #3 rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      check_bit("post_reset_rsp_valid", rsp_valid, 1'b0);
    end
    applyStimulus(1, 32'd100, 32'd23, ALU_SUB);
    repeat (4) @(negedge clk);

    // Both ports requesting every cycle from reset
    pulse_reset();
    grant_log.delete();
    acc0 = 0; acc1 = 0;
    @(posedge clk); #1;
    rsp_ready = 1;
    new_req(0);
    new_req(1);
    repeat (40) begin
      @(posedge clk); #1;
      if (acc0) begin acc0 = 0; new_req(0); end
      if (acc1) begin acc1 = 0; new_req(1); end
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);
    check_bit("alternate_count", grant_log.size() >= 8, 1'b1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      check_bit($sformatf("alternate_grant_%0d", i), grant_log[i],
                (FIXED_PRIO != 0) ? 1'b0 : 1'(i % 2));
    end

    // Random traffic with cancellations and consumer back-pressure
    acc0 = 0; acc1 = 0;
    repeat (400) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom % 4) != 0;
      if (acc0 || !req0_valid) begin
        acc0 = 0;
        if ($urandom % 2 == 1) new_req(0);
        else                   req0_valid = 0;
      end else if ($urandom % 16 == 0) begin
        req0_valid = 0;
      end
      if (acc1 || !req1_valid) begin
        acc1 = 0;
        if ($urandom % 2 == 1) new_req(1);
        else                   req1_valid = 0;
      end else if ($urandom % 16 == 0) begin
        req1_valid = 0;
      end
    end

    // Drain
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (6) @(negedge clk);
    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
